// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared constants and types for the registered ALU control:
//               ALUOp encodings, instruction funct fields, ALU Funct codes,
//               FSM state encoding and the decode result record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALUOp encodings coming from the main decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;
    localparam logic [1:0] c_aluop_ori   = 2'b11;

    // Instruction funct field values recognised for R-type
    localparam logic [5:0] c_fn_add = 6'b001011;
    localparam logic [5:0] c_fn_sub = 6'b001101;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_srl = 6'b000010;
    localparam logic [5:0] c_fn_mul = 6'b011001;

    // ALU operation codes driven on Funct
    localparam logic [5:0] c_funct_none = 6'b000000;
    localparam logic [5:0] c_funct_add  = 6'b001001;
    localparam logic [5:0] c_funct_sub  = 6'b001010;
    localparam logic [5:0] c_funct_or   = 6'b010010;
    localparam logic [5:0] c_funct_srl  = 6'b100010;
    localparam logic [5:0] c_funct_mul  = 6'b000101;

    // Control FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_st_idle     = 1'b0;
    localparam state_t c_st_mul_busy = 1'b1;

    // Result of decoding one request
    typedef struct packed {
        logic [5:0] funct;
        logic       illegal;
        logic       is_mul;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_seq_mul_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : mul_step_counter
// Description : Step index for the shift-add multiplier. Cleared by start,
//               advanced by enable, wraps to zero after the final step and
//               flags the final step combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_step_counter #(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = $clog2(MUL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MUL_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Step index: clear on start, advance per step, wrap after the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = enable && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Registered ALU control. Decodes ALUOp/funct_ctrl into the ALU
//               Funct code behind a valid/ready output slot and sequences a
//               multi-cycle shift-add multiply, holding upstream off until
//               the MUL result code is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = $clog2(MUL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       Funct,
    output logic             illegal,
    output logic             mul_start,
    output logic             mul_step,
    output logic [CNT_W-1:0] mul_cnt,
    output logic             mul_last
);

    // Pure decode of one request; unknown R-type funct yields code 0 + illegal
    function automatic dec_t f_decode(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d.funct   = c_funct_none;
        d.illegal = 1'b0;
        d.is_mul  = 1'b0;
        case (op)
            c_aluop_add: d.funct = c_funct_add;
            c_aluop_sub: d.funct = c_funct_sub;
            c_aluop_ori: d.funct = c_funct_or;
            default: begin
                case (fn)
                    c_fn_add: d.funct = c_funct_add;
                    c_fn_sub: d.funct = c_funct_sub;
                    c_fn_or:  d.funct = c_funct_or;
                    c_fn_srl: d.funct = c_funct_srl;
                    c_fn_mul: begin
                        d.funct  = c_funct_mul;
                        d.is_mul = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

    state_t     r_state;
    logic       r_out_valid;
    logic [5:0] r_funct;
    logic       r_illegal;
    logic       r_mul_start;
    logic       r_mul_step;

    dec_t       w_dec;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_mul_last;

    assign w_dec      = f_decode(ALUOp, funct_ctrl);
    assign w_in_ready = (r_state == c_st_idle) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // Output slot and IDLE/MUL_BUSY sequencing; a MUL spends one load cycle
    // (mul_start) then MUL_CYCLES step cycles before the result is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_out_valid <= 1'b0;
            r_funct     <= c_funct_none;
            r_illegal   <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_step  <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (w_accept) begin
                if (w_dec.is_mul) begin
                    // Any pending result retires this edge; slot stays empty
                    r_state     <= c_st_mul_busy;
                    r_mul_start <= 1'b1;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= 1'b1;
                    r_funct     <= w_dec.funct;
                    r_illegal   <= w_dec.illegal;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else begin
            if (r_mul_start) begin
                r_mul_start <= 1'b0;
                r_mul_step  <= 1'b1;
            end else if (w_mul_last) begin
                r_mul_step  <= 1'b0;
                r_state     <= c_st_idle;
                r_out_valid <= 1'b1;
                r_funct     <= c_funct_mul;
                r_illegal   <= 1'b0;
            end
        end
    end

    mul_step_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mul_step_counter (
        .clk    (clk),
        .rst    (rst),
        .start  (r_mul_start),
        .enable (r_mul_step),
        .cnt    (mul_cnt),
        .last   (w_mul_last)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign Funct     = r_funct;
    assign illegal   = r_illegal;
    assign mul_start = r_mul_start;
    assign mul_step  = r_mul_step;
    assign mul_last  = w_mul_last;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Directed self-checking bench for alu_ctrl_seq with a
//               four-step multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int MUL_CYCLES = 4;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [5:0]       funct_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       Funct;
    logic             illegal;
    logic             mul_start;
    logic             mul_step;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_last;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_seq #(
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .funct_ctrl (funct_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Funct      (Funct),
        .illegal    (illegal),
        .mul_start  (mul_start),
        .mul_step   (mul_step),
        .mul_cnt    (mul_cnt),
        .mul_last   (mul_last)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ALUOp      = 2'b00;
        funct_ctrl = 6'b000000;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_funct",     32'(Funct),     32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_mul_step",  32'(mul_step),  32'd0);
        chk("rst_mul_cnt",   32'(mul_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // R-type add, latency one
        in_valid = 1'b1; ALUOp = 2'b10; funct_ctrl = 6'b001011;
        tick();
        chk("t1_valid",   32'(out_valid), 32'd1);
        chk("t1_funct",   32'(Funct),     32'h09);
        chk("t1_illegal", 32'(illegal),   32'd0);

        // Back-to-back ALUOp 00, 01, 11
        ALUOp = 2'b00; tick();
        chk("t2_add", 32'(Funct), 32'h09);
        ALUOp = 2'b01; tick();
        chk("t2_sub", 32'(Funct), 32'h0A);
        chk("t2_sub_valid", 32'(out_valid), 32'd1);
        ALUOp = 2'b11; tick();
        chk("t2_ori", 32'(Funct), 32'h12);

        // R-type srl
        ALUOp = 2'b10; funct_ctrl = 6'b000010; tick();
        chk("srl_funct", 32'(Funct), 32'h22);

        // Unknown funct
        funct_ctrl = 6'b111111; tick();
        chk("t3_valid",   32'(out_valid), 32'd1);
        chk("t3_funct",   32'(Funct),     32'd0);
        chk("t3_illegal", 32'(illegal),   32'd1);

        // Idle retire
        in_valid = 1'b0; tick();
        chk("retire_valid", 32'(out_valid), 32'd0);

        // MUL sequencing
        in_valid = 1'b1; ALUOp = 2'b10; funct_ctrl = 6'b011001;
        #1;
        chk("t4_ready_pre", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_start",     32'(mul_start), 32'd1);
        chk("t4_start_stp", 32'(mul_step),  32'd0);
        chk("t4_start_cnt", 32'(mul_cnt),   32'd0);
        chk("t4_start_rdy", 32'(in_ready),  32'd0);
        chk("t4_start_ov",  32'(out_valid), 32'd0);
        for (int i = 0; i < MUL_CYCLES; i++) begin
            tick();
            chk("t4_step",  32'(mul_step),  32'd1);
            chk("t4_cnt",   32'(mul_cnt),   32'(i));
            chk("t4_last",  32'(mul_last),  (i == MUL_CYCLES - 1) ? 32'd1 : 32'd0);
            chk("t4_start_low", 32'(mul_start), 32'd0);
            chk("t4_rdy",   32'(in_ready),  32'd0);
            chk("t4_ov",    32'(out_valid), 32'd0);
        end
        tick();
        chk("t4_res_valid", 32'(out_valid), 32'd1);
        chk("t4_res_funct", 32'(Funct),     32'h05);
        chk("t4_res_ill",   32'(illegal),   32'd0);
        chk("t4_res_step",  32'(mul_step),  32'd0);
        chk("t4_res_cnt",   32'(mul_cnt),   32'd0);

        // Backpressure: result held, new request ignored
        out_ready = 1'b0;
        in_valid  = 1'b1; ALUOp = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_funct", 32'(Funct),     32'h05);
            chk("t5_hold_rdy",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t5_rdy_release", 32'(in_ready), 32'd1);
        tick();
        chk("t5_reload_valid", 32'(out_valid), 32'd1);
        chk("t5_reload_funct", 32'(Funct),     32'h0A);
        in_valid = 1'b0; tick();
        chk("t5_drain", 32'(out_valid), 32'd0);

        // MUL entry while a result retires, then reset mid-MUL
        in_valid = 1'b1; ALUOp = 2'b00; tick();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        ALUOp = 2'b10; funct_ctrl = 6'b011001; tick();
        in_valid = 1'b0;
        chk("t6_entry_ov",    32'(out_valid), 32'd0);
        chk("t6_entry_start", 32'(mul_start), 32'd1);
        tick(); tick(); tick();
        chk("t6_cnt2", 32'(mul_cnt), 32'd2);
        chk("t6_step", 32'(mul_step), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_cnt",   32'(mul_cnt),   32'd0);
        chk("t6_async_step",  32'(mul_step),  32'd0);
        chk("t6_async_start", 32'(mul_start), 32'd0);
        chk("t6_async_ov",    32'(out_valid), 32'd0);
        chk("t6_async_funct", 32'(Funct),     32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2 * MUL_CYCLES; i++) begin
            tick();
            chk("t6_no_result", 32'(out_valid), 32'd0);
            chk("t6_idle_step", 32'(mul_step),  32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
